// File: rtl/tft_framebuffer_scan.sv
// ---------------------------------------------------------------------------
// tft_framebuffer_scan
//
// Pixel source for the ILI9341 SPI driver. A reduced-resolution RGB565 frame
// buffer lives in a dual-port RAM. Each rising edge of the driver's pix_clk
// requests the next panel pixel in raster order. Every buffer pixel is
// replicated 2^SCALE_LOG2 times in both axes to fill DISP_W x DISP_H.
// A host or drawing agent can write the buffer at any time, including while
// the buffer is being scanned out.
//
// Optional feature, enabled by defining TFT_FB_CLEAR_EN:
//   hardware fill of the whole buffer with clear_color, one word per cycle.
//   When the macro is undefined, clear_req and clear_color are ignored and
//   clear_busy is tied to 0.
//
// Ports:
//   clk          system clock, shared with the TFT driver
//   rst_n        asynchronous active-low reset
//   pix_clk      driver framebuffer clock; a rising edge requests one pixel
//   pix_data     RGB565 pixel presented to the driver (2-cycle latency)
//   frame_start  one-cycle pulse when pixel (0,0) is loaded onto pix_data
//   wr_en        write strobe
//   wr_x, wr_y   buffer column and row of the write
//   wr_data      RGB565 pixel to write
//   wr_err       one-cycle pulse, one cycle after an out-of-range write
//   clear_req    start a buffer clear
//   clear_color  fill colour for the clear
//   clear_busy   clear in progress
// ---------------------------------------------------------------------------
module tft_framebuffer_scan #(
  parameter int DISP_W     = 320,
  parameter int DISP_H     = 240,
  parameter int SCALE_LOG2 = 1,
  parameter int ADDR_W     = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_clk,
  output logic [15:0] pix_data,
  output logic        frame_start,
  input  logic        wr_en,
  input  logic [8:0]  wr_x,
  input  logic [7:0]  wr_y,
  input  logic [15:0] wr_data,
  output logic        wr_err,
  input  logic        clear_req,
  input  logic [15:0] clear_color,
  output logic        clear_busy
);

  localparam int FB_W    = DISP_W >> SCALE_LOG2;
  localparam int FB_H    = DISP_H >> SCALE_LOG2;
  localparam int FB_SIZE = FB_W * FB_H;
  localparam int XW      = $clog2(DISP_W);
  localparam int YW      = $clog2(DISP_H);

  // Low y bits that select the replicated line within one buffer row.
  localparam logic [YW-1:0] Y_SUB_MASK = YW'((1 << SCALE_LOG2) - 1);

  logic [15:0]       mem [FB_SIZE];
  logic [15:0]       ram_q;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [15:0]       ram_wdata;

  logic              pix_clk_q;
  logic              req;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic              rd_first;

  logic              wr_in_range;
  logic [ADDR_W-1:0] wr_addr;

  assign req     = pix_clk & ~pix_clk_q;
  assign rd_addr = row_base + ADDR_W'(x >> SCALE_LOG2);

  assign wr_in_range = (wr_x < 9'(FB_W)) && (wr_y < 8'(FB_H));

  // wr_y * FB_W built from shifted copies of wr_y, one per set bit of the
  // constant FB_W, so no multiplier is inferred.
  always_comb begin
    wr_addr = ADDR_W'(wr_x);
    for (int i = 0; i < ADDR_W; i++) begin
      if (FB_W[i]) wr_addr = wr_addr + (ADDR_W'(wr_y) << i);
    end
  end

  // Dual-port RAM with a registered read port. The read samples the array
  // before this edge's write lands, so a same-address collision is read-first.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_q <= mem[rd_addr];
  end

  // Request edge detect, raster counters and the output stage. The read
  // issued in the request cycle is tracked by rd_valid so pix_data only
  // changes two cycles after a request; reset drops any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_clk_q   <= 1'b0;
      x           <= '0;
      y           <= '0;
      row_base    <= '0;
      rd_valid    <= 1'b0;
      rd_first    <= 1'b0;
      pix_data    <= 16'h0000;
      frame_start <= 1'b0;
      wr_err      <= 1'b0;
    end else begin
      pix_clk_q   <= pix_clk;
      rd_valid    <= req;
      rd_first    <= req && (x == '0) && (y == '0);
      frame_start <= rd_valid && rd_first;
      wr_err      <= wr_en && !wr_in_range && !clear_busy;
      if (rd_valid) pix_data <= ram_q;

      if (req) begin
        if (x == XW'(DISP_W - 1)) begin
          x <= '0;
          if (y == YW'(DISP_H - 1)) begin
            y        <= '0;
            row_base <= '0;
          end else begin
            y <= y + 1'b1;
            // Step to the next buffer row only after the last replicated line.
            if ((y & Y_SUB_MASK) == Y_SUB_MASK) row_base <= row_base + ADDR_W'(FB_W);
          end
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

`ifdef TFT_FB_CLEAR_EN

  typedef enum logic {CLR_IDLE, CLR_BUSY} clr_state_t;

  clr_state_t        clr_state, clr_state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic [15:0]       clr_color, clr_color_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_state <= CLR_IDLE;
      clr_cnt   <= '0;
      clr_color <= 16'h0000;
    end else begin
      clr_state <= clr_state_nxt;
      clr_cnt   <= clr_cnt_nxt;
      clr_color <= clr_color_nxt;
    end
  end

  // A request is accepted only while idle; once busy, further requests are
  // ignored and the counter sweeps every buffer address exactly once.
  always_comb begin
    clr_state_nxt = clr_state;
    clr_cnt_nxt   = clr_cnt;
    clr_color_nxt = clr_color;
    case (clr_state)
      CLR_IDLE: begin
        if (clear_req) begin
          clr_state_nxt = CLR_BUSY;
          clr_cnt_nxt   = '0;
          clr_color_nxt = clear_color;
        end
      end
      CLR_BUSY: begin
        if (clr_cnt == ADDR_W'(FB_SIZE - 1)) clr_state_nxt = CLR_IDLE;
        else clr_cnt_nxt = clr_cnt + 1'b1;
      end
      default: clr_state_nxt = CLR_IDLE;
    endcase
  end

  assign clear_busy = (clr_state == CLR_BUSY);

  // The clear owns the write port while busy; host writes are dropped silently.
  always_comb begin
    ram_we    = wr_en && wr_in_range;
    ram_waddr = wr_addr;
    ram_wdata = wr_data;
    if (clear_busy) begin
      ram_we    = 1'b1;
      ram_waddr = clr_cnt;
      ram_wdata = clr_color;
    end
  end

`else

  logic unused_clear;
  assign unused_clear = clear_req ^ (^clear_color);
  assign clear_busy   = 1'b0;

  always_comb begin
    ram_we    = wr_en && wr_in_range;
    ram_waddr = wr_addr;
    ram_wdata = wr_data;
  end

`endif

endmodule
